// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM line loader: default intensity width,
// fill-state encoding and the terminal-count helper.
package pwm_pkg;

  localparam int DEF_DW = 8;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_t;

  // Terminal count of a free-running counter of width w (all ones).
  function automatic logic [31:0] term_count(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/pwm_line_loader_if.sv
// Pixel stream handshake into the line loader: the source drives data/valid,
// the loader answers with ready. A transfer happens when valid && ready.
interface pwm_line_loader_if #(
  parameter int DW = 8
);
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/pwm_line_bank.sv
// N_CH x DW register array. Supports a single-entry indexed write, a
// whole-line load, a synchronous clear and an asynchronous reset clear.
// Read port is the whole line as a flat vector, channel i at [DW*i +: DW].
// Priority: clr > ld > we.
module pwm_line_bank #(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int IW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               ld,
  input  logic [N_CH*DW-1:0] ld_data,
  input  logic               we,
  input  logic [IW-1:0]      widx,
  input  logic [DW-1:0]      wdata,
  output logic [N_CH*DW-1:0] rd_data
);

  logic [N_CH-1:0][DW-1:0] mem;

  // Update the line storage: clear, whole-line load, or single-entry write.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the array is reset as a whole because a reset must blank the
    // displayed line immediately; a memory without reset would not allow that.
    if (rst) begin
      mem <= '0;
    end else if (clr) begin
      mem <= '0;
    end else if (ld) begin
      mem <= ld_data;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/pwm_line_loader.sv
// Line loader feeding N_CH PWM blocks. Pixels are assembled into a back bank
// and swapped into the front bank at the counter's terminal count; hsync
// pulses low for one cycle at every swap.
// Build option: define PWM_LINE_REPEAT_EN to repeat the previous line on an
// underrun; by default an underrun shows a blank (all-zero) line.
module pwm_line_loader
  import pwm_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = DEF_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      count,
  pwm_line_loader_if.slave   pix,
  output logic [N_CH*DW-1:0] data,
  output logic               hsync,
  output logic               underrun
);

  // Index width stays at least one bit so a single-channel build still works.
  localparam int            IW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_CH - 1);
  localparam logic [DW-1:0] TC   = DW'(term_count(DW));

  fill_state_t          state;
  logic [IW-1:0]        idx;
  logic                 started;
  logic                 tc;
  logic                 xfer;
  logic                 swap;
  logic                 blank;
  logic [N_CH*DW-1:0]   back_line;
  logic [N_CH*DW-1:0]   front_line;

  assign tc            = (count == TC);
  assign pix.pix_ready = (state == FILL);
  assign xfer          = pix.pix_valid && pix.pix_ready;

  // The swap uses the pre-edge state, so a line completed on the swap edge
  // itself waits for the next terminal count.
  assign swap = tc && (state == FULL);

`ifdef PWM_LINE_REPEAT_EN
  assign blank = 1'b0;
`else
  assign blank = tc && (state == FILL) && started;
`endif

  // Fill FSM plus registered hsync/underrun; hsync idles at 'started' so it
  // stays low until the first line has been shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      idx      <= '0;
      started  <= 1'b0;
      hsync    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every branch below see the
      // pre-edge state, which is exactly the swap-decision rule we need.
      hsync    <= started;
      underrun <= 1'b0;
      case (state)
        FILL: begin
          if (tc && started) begin
            underrun <= 1'b1;
            hsync    <= 1'b0;
          end
          if (xfer) begin
            if (idx == LAST) begin
              state <= FULL;
              idx   <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        FULL: begin
          if (tc) begin
            state   <= FILL;
            hsync   <= 1'b0;
            started <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  pwm_line_bank #(.N_CH(N_CH), .DW(DW), .IW(IW)) u_back (
    .clk     (clk),
    .rst     (rst),
    .clr     (1'b0),
    .ld      (1'b0),
    .ld_data ('0),
    .we      (xfer),
    .widx    (idx),
    .wdata   (pix.pix_data),
    .rd_data (back_line)
  );

  pwm_line_bank #(.N_CH(N_CH), .DW(DW), .IW(IW)) u_front (
    .clk     (clk),
    .rst     (rst),
    .clr     (blank),
    .ld      (swap),
    .ld_data (back_line),
    .we      (1'b0),
    .widx    ('0),
    .wdata   ('0),
    .rd_data (front_line)
  );

  // The front bank is itself a register, so data is registered as well.
  assign data = front_line;

endmodule

// File: tb/tb_pwm_line_loader.sv
// Directed testbench for pwm_line_loader (N_CH=4, DW=8). The bench drives
// count itself so each edge can be placed relative to the terminal count.
module tb_pwm_line_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  count = 8'h00;
  logic [31:0] data;
  logic        hsync;
  logic        underrun;

  int n_checks = 0;
  int n_pass   = 0;

  pwm_line_loader_if #(.DW(8)) pix ();

  pwm_line_loader #(.N_CH(4), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .pix      (pix),
    .data     (data),
    .hsync    (hsync),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] LINE1 = 32'h281E_140A;
`ifdef PWM_LINE_REPEAT_EN
  localparam logic [31:0] UND_DATA  = LINE1;
  localparam logic [31:0] RACE_DATA = 32'hA8A7_A6A5;
`else
  localparam logic [31:0] UND_DATA  = 32'h0;
  localparam logic [31:0] RACE_DATA = 32'h0;
`endif

  typedef struct {
    logic        valid;
    logic [7:0]  pdata;
    logic [7:0]  cnt;
    logic        exp_ready;
    logic [31:0] exp_data;
    logic        exp_hsync;
    logic        exp_under;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock edge with the current inputs; returns 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [7:0] c);
    pix.pix_valid = v;
    pix.pix_data  = d;
    count         = c;
  endtask

  logic [7:0] bp[12];
  int         k;
  logic       rdy;
  logic       saw_under;
  logic       saw_hs;
  logic       saw_change;

  initial begin
    // Reset then first line, underrun: {inputs before edge, outputs after edge}
    vt[0]  = '{1'b1, 8'd10,  8'hF0, 1'b1, 32'h0,    1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'd20,  8'hF1, 1'b1, 32'h0,    1'b0, 1'b0};
    vt[2]  = '{1'b1, 8'd30,  8'hF2, 1'b1, 32'h0,    1'b0, 1'b0};
    vt[3]  = '{1'b1, 8'd40,  8'hF3, 1'b0, 32'h0,    1'b0, 1'b0};
    vt[4]  = '{1'b1, 8'h55,  8'hF4, 1'b0, 32'h0,    1'b0, 1'b0};
    vt[5]  = '{1'b0, 8'h00,  8'hFE, 1'b0, 32'h0,    1'b0, 1'b0};
    vt[6]  = '{1'b0, 8'h00,  8'hFF, 1'b1, LINE1,    1'b0, 1'b0};
    vt[7]  = '{1'b0, 8'h00,  8'h00, 1'b1, LINE1,    1'b1, 1'b0};
    vt[8]  = '{1'b0, 8'h00,  8'h7F, 1'b1, LINE1,    1'b1, 1'b0};
    vt[9]  = '{1'b0, 8'h00,  8'hFE, 1'b1, LINE1,    1'b1, 1'b0};
    vt[10] = '{1'b0, 8'h00,  8'hFF, 1'b1, UND_DATA, 1'b0, 1'b1};
    vt[11] = '{1'b0, 8'h00,  8'h00, 1'b1, UND_DATA, 1'b1, 1'b0};
    vt[12] = '{1'b0, 8'h00,  8'h01, 1'b1, UND_DATA, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) bp[i] = 8'hA1 + 8'(i);

    // Reset state
    drive(1'b0, 8'h00, 8'h00);
    #1;
    check("rst_data",  data,          64'h0);
    check("rst_hsync", hsync,         64'h0);
    check("rst_under", underrun,      64'h0);
    check("rst_ready", pix.pix_ready, 64'h1);
    tick();
    tick();
    #3 rst = 1'b0;

    // Table-driven first line and underrun
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].valid, vt[i].pdata, vt[i].cnt);
      tick();
      check($sformatf("v%0d_ready", i), pix.pix_ready, 64'(vt[i].exp_ready));
      check($sformatf("v%0d_data",  i), data,          64'(vt[i].exp_data));
      check($sformatf("v%0d_hsync", i), hsync,         64'(vt[i].exp_hsync));
      check($sformatf("v%0d_under", i), underrun,      64'(vt[i].exp_under));
    end

    // Backpressure: valid held high, source advances only on transfers
    k = 0;
    for (int c = 8'hF8; c <= 8'hFF; c++) begin
      drive(1'b1, bp[k], 8'(c));
      rdy = pix.pix_ready;
      if (k >= 4) check($sformatf("bp_hold_%0h", c), rdy, 64'h0);
      tick();
      if (rdy) k++;
    end
    check("bp_xfers_line1", k,        64'd4);
    check("bp_swap_data",   data,     64'hA4A3_A2A1);
    check("bp_swap_hsync",  hsync,    64'h0);
    check("bp_swap_under",  underrun, 64'h0);
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, bp[k], 8'(c));
      rdy = pix.pix_ready;
      if (c == 0) check("bp_ready_after_swap", rdy, 64'h1);
      tick();
      if (rdy) k++;
    end
    check("bp_xfers_line2", k, 64'd8);
    drive(1'b0, 8'h00, 8'hFF);
    tick();
    check("bp_line2_data", data, 64'hA8A7_A6A5);

    // Race: 4th transfer lands on the terminal-count edge
    drive(1'b1, 8'hB1, 8'hFC); tick();
    drive(1'b1, 8'hB2, 8'hFD); tick();
    drive(1'b1, 8'hB3, 8'hFE); tick();
    drive(1'b1, 8'hB4, 8'hFF); tick();
    check("race_under", underrun,      64'h1);
    check("race_hsync", hsync,         64'h0);
    check("race_ready", pix.pix_ready, 64'h0);
    check("race_data",  data,          64'(RACE_DATA));
    saw_under  = 1'b0;
    saw_change = 1'b0;
    for (int c = 0; c < 255; c++) begin
      drive(1'b0, 8'h00, 8'(c));
      tick();
      if (underrun) saw_under = 1'b1;
      if (data !== RACE_DATA) saw_change = 1'b1;
    end
    check("race_wait_under", saw_under,  64'h0);
    check("race_wait_data",  saw_change, 64'h0);
    check("race_wait_hsync", hsync,      64'h1);
    drive(1'b0, 8'h00, 8'hFF); tick();
    check("race_swap_data",  data,     64'hB4B3_B2B1);
    check("race_swap_hsync", hsync,    64'h0);
    check("race_swap_under", underrun, 64'h0);
    drive(1'b0, 8'h00, 8'h00); tick();
    check("race_post_hsync", hsync, 64'h1);

    // Mid-fill reset, asserted and released between edges
    drive(1'b1, 8'hC1, 8'h10); tick();
    drive(1'b1, 8'hC2, 8'h11); tick();
    drive(1'b0, 8'h00, 8'h12);
    #3 rst = 1'b1;
    #1;
    check("mrst_data",  data,          64'h0);
    check("mrst_hsync", hsync,         64'h0);
    check("mrst_ready", pix.pix_ready, 64'h1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    drive(1'b1, 8'hD1, 8'h20); tick();
    drive(1'b1, 8'hD2, 8'h21); tick();
    drive(1'b1, 8'hD3, 8'h22); tick();
    drive(1'b1, 8'hD4, 8'h23); tick();
    check("mrst_full", pix.pix_ready, 64'h0);
    drive(1'b0, 8'h00, 8'hFF); tick();
    check("mrst_line_data",  data,     64'hD4D3_D2D1);
    check("mrst_line_hsync", hsync,    64'h0);
    check("mrst_line_under", underrun, 64'h0);
    drive(1'b0, 8'h00, 8'h00); tick();
    check("mrst_post_hsync", hsync, 64'h1);

    // Pre-start idle: three full counter periods without data
    #3 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    saw_under = 1'b0;
    saw_hs    = 1'b0;
    for (int c = 0; c < 768; c++) begin
      drive(1'b0, 8'h00, 8'(c));
      tick();
      if (underrun) saw_under = 1'b1;
      if (hsync)    saw_hs    = 1'b1;
    end
    check("idle_under", saw_under, 64'h0);
    check("idle_hsync", saw_hs,    64'h0);
    check("idle_data",  data,      64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
